// File: rtl/uart_autobaud.sv
// uart_autobaud: rxd synchroniser and 0x55 auto-baud measurement unit.
//
// Sits between the rxd pad and the UART receiver. The synchronised line is
// always forwarded on rxd_o. While en_i is high, the block waits for an idle
// line. It then times the five falling edges of a host-sent 0x55 ('U')
// character and produces the 16x-oversample divisor (8 bit periods / 128,
// rounded).
//
// Ports:
//   clk_i      primary clock
//   rst_ni     asynchronous active-low reset
//   rxd_i      raw serial line from the pad (asynchronous)
//   rxd_o      synchronised serial line for the UART
//   en_i       1 = arm / continue a measurement, 0 = abort and idle
//   busy_o     high whenever the FSM is not IDLE
//   done_o     one-cycle pulse: divisor_o was updated
//   err_o      one-cycle pulse: measurement rejected
//   divisor_o  last successful divisor, held until the next success
//
// Handshake: done_o and err_o are single-cycle strobes, never high together.
// No ready is involved. divisor_o is valid from the done_o cycle onward.
module uart_autobaud #(
    parameter int SyncStages = 2,
    parameter int CntWidth   = 24,
    parameter int DivWidth   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rxd_i,
    output logic                rxd_o,
    input  logic                en_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [DivWidth-1:0] divisor_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HIGH,
        ARMED,
        MEASURE
    } state_e;

    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam logic [CntWidth:0]   DivMax = (CntWidth+1)'((64'd1 << DivWidth) - 64'd1);
    localparam logic [CntWidth:0]   Round  = (CntWidth+1)'(64);

    state_e                state_q;
    logic [SyncStages-1:0] sync_q;
    logic                  s_prev_q;
    logic [CntWidth-1:0]   ivl_q;
    logic [CntWidth-1:0]   total_q;
    logic [CntWidth-1:0]   t1_q;
    logic [1:0]            edges_q;
    logic [DivWidth-1:0]   divisor_q;
    logic                  done_q;
    logic                  err_q;

    logic                  s;
    logic                  fe;
    logic [CntWidth-1:0]   ivl_d;
    logic [CntWidth-1:0]   total_d;
    logic [CntWidth:0]     bound_hi;
    logic [CntWidth:0]     bound_lo;
    logic [CntWidth:0]     div_d;
    logic                  too_long;
    logic                  too_short;
    logic                  saturated;
    logic                  div_bad;
    logic                  fail;

    // Synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= '1;
            s_prev_q <= 1'b1;
        end else begin
            sync_q   <= {sync_q[SyncStages-2:0], rxd_i};
            s_prev_q <= s;
        end
    end

    assign s     = sync_q[SyncStages-1];
    assign rxd_o = s;
    assign fe    = ~s & s_prev_q;

    // Counts as they stand in the current cycle. On a falling edge, ivl_d
    // therefore includes the edge cycle itself.
    assign ivl_d   = ivl_q + 1'b1;
    assign total_d = total_q + 1'b1;

    // +/-25% window around T1. One extra bit keeps T1 + T1/4 from wrapping.
    assign bound_hi = {1'b0, t1_q} + {3'b000, t1_q[CntWidth-1:2]};
    assign bound_lo = {1'b0, t1_q} - {3'b000, t1_q[CntWidth-1:2]};

    assign too_long  = (edges_q != 2'd0) && ({1'b0, ivl_d} > bound_hi);
    assign too_short = fe && (edges_q != 2'd0) && ({1'b0, ivl_d} < bound_lo);
    assign saturated = (ivl_d == CntMax) || (total_d == CntMax);

    // 8 bit periods / (16 * 8), rounded to nearest.
    assign div_d   = ({1'b0, total_d} + Round) >> 7;
    assign div_bad = (div_d == '0) || (div_d > DivMax);
    assign fail    = saturated || too_long || too_short
                   || (fe && (edges_q == 2'd3) && div_bad);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ivl_q     <= '0;
            total_q   <= '0;
            t1_q      <= '0;
            edges_q   <= '0;
            divisor_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en_i) state_q <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    // Skip any frame already in flight when we were armed.
                    if (!en_i)  state_q <= IDLE;
                    else if (s) state_q <= ARMED;
                end
                ARMED: begin
                    if (!en_i) begin
                        state_q <= IDLE;
                    end else if (fe) begin
                        state_q <= MEASURE;
                        ivl_q   <= '0;
                        total_q <= '0;
                        edges_q <= '0;
                    end
                end
                MEASURE: begin
                    if (!en_i) begin
                        state_q <= IDLE;
                    end else if (fail) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        total_q <= total_d;
                        // Clearing to 0 makes the next cycle's count start at 1.
                        ivl_q   <= fe ? '0 : ivl_d;
                        if (fe) begin
                            edges_q <= edges_q + 2'd1;
                            if (edges_q == 2'd0) t1_q <= ivl_d;
                            if (edges_q == 2'd3) begin
                                divisor_q <= div_d[DivWidth-1:0];
                                done_q    <= 1'b1;
                                state_q   <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign divisor_o = divisor_q;

endmodule

// File: tb/tb_uart_autobaud.sv
// Bench for uart_autobaud: timestamp-based behavioural model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_uart_autobaud;

    localparam int    SYNC    = 2;
    localparam longint CNTMAX = (64'd1 << 24) - 1;
    localparam longint DIVMAX = 65535;

    localparam int M_IDLE = 0, M_WAIT = 1, M_ARMED = 2, M_MEAS = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxd;
    logic        en;
    logic        rxd_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] divisor_o;

    uart_autobaud #(.SyncStages(SYNC), .CntWidth(24), .DivWidth(16)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .rxd_i    (rxd),
        .rxd_o    (rxd_o),
        .en_i     (en),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .err_o    (err_o),
        .divisor_o(divisor_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_n = 0;
    int err_n  = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Line history as a delay queue, measurement as absolute timestamps of
    // falling edges: ivl = now - last edge, total = now - first edge.
    logic   sq[$];
    logic   m_s, m_sprev;
    int     m_state;
    longint cyc, t0, tl, t1;
    int     n_edges;
    logic   m_done, m_err;
    longint m_div;

    task automatic model_reset();
        sq.delete();
        for (int i = 0; i < SYNC - 1; i++) sq.push_back(1'b1);
        m_s = 1'b1; m_sprev = 1'b1;
        m_state = M_IDLE;
        m_done = 1'b0; m_err = 1'b0; m_div = 0;
        n_edges = 0; t0 = 0; tl = 0; t1 = 0;
    endtask

    task automatic model_step(input logic r, input logic e);
        logic   fe, fail;
        longint ivl, tot, d;
        fe = (m_s == 1'b0) && (m_sprev == 1'b1);
        m_done = 1'b0; m_err = 1'b0;
        cyc++;
        if (!e) begin
            m_state = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE:  m_state = M_WAIT;
                M_WAIT:  if (m_s) m_state = M_ARMED;
                M_ARMED: if (fe) begin t0 = cyc; tl = cyc; n_edges = 0; m_state = M_MEAS; end
                default: begin
                    ivl = cyc - tl;
                    tot = cyc - t0;
                    d = 0;
                    fail = (ivl >= CNTMAX) || (tot >= CNTMAX)
                        || (n_edges > 0 && ivl > t1 + t1 / 4)
                        || (fe && n_edges > 0 && ivl < t1 - t1 / 4);
                    if (!fail && fe && n_edges == 3) begin
                        d = (tot + 64) / 128;
                        if (d == 0 || d > DIVMAX) fail = 1'b1;
                    end
                    if (fail) begin
                        m_err = 1'b1; m_state = M_IDLE;
                    end else if (fe) begin
                        if (n_edges == 0) t1 = ivl;
                        n_edges++;
                        tl = cyc;
                        if (n_edges == 4) begin
                            m_div = d; m_done = 1'b1; m_state = M_IDLE;
                        end
                    end
                end
            endcase
        end
        m_sprev = m_s;
        sq.push_back(r);
        m_s = sq.pop_front();
    endtask

    // One compare process: model advances on each edge, DUT sampled 1 ns later.
    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step(rxd, en);
        #1;
        if (chk_on) begin
            check("busy",    busy_o,    (m_state != M_IDLE) ? 1 : 0);
            check("done",    done_o,    m_done);
            check("err",     err_o,     m_err);
            check("divisor", divisor_o, m_div);
            check("rxd_o",   rxd_o,     m_s);
            if (done_o) done_n++;
            if (err_o)  err_n++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drop en_i briefly so each scenario starts from a freshly armed FSM.
    task automatic rearm();
        @(negedge clk); en = 1'b0;
        idle(2);
        en = 1'b1;
        idle(10);
    endtask

    // 8N1 frame, p cycles/bit. glitch_at: 3-cycle low pulse start (-1 none).
    // drop_at: cycle at which en is released (-1 none).
    task automatic send_frame(input logic [7:0] b, input int p,
                              input int glitch_at, input int drop_at);
        logic [9:0] bits;
        bits = {1'b1, b, 1'b0};
        for (int c = 0; c < 10 * p; c++) begin
            @(negedge clk);
            rxd = bits[c / p];
            if (glitch_at >= 0 && c >= glitch_at && c < glitch_at + 3) rxd = 1'b0;
            if (c == drop_at) en = 1'b0;
        end
        @(negedge clk);
        rxd = 1'b1;
    endtask

    int d0, e0, p;
    logic [7:0] rb;

    initial begin
        rst_n = 1'b0; rxd = 1'b1; en = 1'b0;
        cyc = 0;
        model_reset();
        idle(4);
        #1;
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_err",  err_o,  0);
        check("reset_div",  divisor_o, 0);
        check("reset_rxd",  rxd_o,  1);
        @(negedge clk); rst_n = 1'b1; chk_on = 1'b1;

        // 0x55 at 868 cycles/bit: (6944+64)>>7 = 54
        rearm();
        d0 = done_n; e0 = err_n;
        send_frame(8'h55, 868, -1, -1);
        idle(50);
        check("t868_done", done_n - d0, 1);
        check("t868_err",  err_n - e0, 0);
        check("t868_div",  divisor_o, 54);

        // 27 cycles/bit: 216 -> 2; then 4 cycles/bit: 32 -> 0 -> error
        rearm();
        d0 = done_n; e0 = err_n;
        send_frame(8'h55, 27, -1, -1);
        idle(60);
        check("t27_done", done_n - d0, 1);
        check("t27_div",  divisor_o, 2);
        d0 = done_n;
        send_frame(8'h55, 4, -1, -1);
        idle(20);
        check("t4_err",  err_n - e0, 1);
        check("t4_done", done_n - d0, 0);
        check("t4_div",  divisor_o, 2);

        // 0x41: second interval exceeds T1+T1/4 = 2170
        rearm();
        d0 = done_n; e0 = err_n;
        send_frame(8'h41, 868, -1, -1);
        idle(50);
        check("t41_err",  err_n - e0, 1);
        check("t41_done", done_n - d0, 0);
        check("t41_div",  divisor_o, 2);

        // Glitch in first data bit -> short interval error. The frame's tail
        // is re-measured and times out in the idle gap (second error), then
        // a clean 0x55 at 100 cycles/bit gives (800+64)>>7 = 6.
        rearm();
        d0 = done_n; e0 = err_n;
        send_frame(8'h55, 100, 150, -1);
        idle(400);
        send_frame(8'h55, 100, -1, -1);
        idle(50);
        check("glitch_err",  err_n - e0, 2);
        check("glitch_done", done_n - d0, 1);
        check("glitch_div",  divisor_o, 6);

        // en dropped after the third falling edge (cycle 400)
        rearm();
        d0 = done_n; e0 = err_n;
        send_frame(8'h55, 100, -1, 410);
        check("drop_busy", busy_o, 0);
        check("drop_done", done_n - d0, 0);
        check("drop_err",  err_n - e0, 0);
        check("drop_div",  divisor_o, 6);

        // Line held low when en rises: no measurement until it goes high.
        @(negedge clk); rxd = 1'b0;
        idle(20);
        en = 1'b1;
        d0 = done_n; e0 = err_n;
        idle(100);
        check("low_busy", busy_o, 1);
        rxd = 1'b1;
        idle(30);
        send_frame(8'h55, 50, -1, -1);
        idle(100);
        check("low_done", done_n - d0, 1);
        check("low_err",  err_n - e0, 0);
        check("low_div",  divisor_o, 3);

        // Asynchronous reset in the middle of MEASURE.
        rearm();
        fork
            send_frame(8'h55, 100, -1, -1);
            begin
                idle(450);
                #3 rst_n = 1'b0;
                #1;
                check("mid_rst_busy", busy_o, 0);
                check("mid_rst_done", done_o, 0);
                check("mid_rst_err",  err_o,  0);
                check("mid_rst_div",  divisor_o, 0);
                check("mid_rst_rxd",  rxd_o,  1);
                idle(5);
                rst_n = 1'b1;
            end
        join
        idle(50);
        check("post_rst_div", divisor_o, 0);

        // Randomised frames, periods and glitches against the model.
        for (int i = 0; i < 14; i++) begin
            rearm();
            p  = $urandom_range(6, 40);
            rb = ($urandom_range(0, 1) == 1) ? 8'h55 : 8'($urandom);
            send_frame(rb, p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9 * p) : -1, -1);
            idle(3 * p + $urandom_range(0, 20));
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_autobaud.md
Name: uart_autobaud

Overview:
- Sits directly upstream of the UART receiver, between the rxd pad and the UART's rxd_i input.
- Synchronises the raw serial line and forwards it to the UART.
- On request, measures a host-sent 0x55 ('U') calibration character and produces the 16x-oversample divisor for software to write into the UART divisor latch.
- Rejects malformed or noisy calibration frames with an error pulse.

Parameters:
- SyncStages, 2, number of synchroniser flops on rxd_i (>=2).
- CntWidth, 24, width of the interval and total cycle counters.
- DivWidth, 16, width of divisor_o.

Ports:
- clk_i  input  1  primary clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- rxd_i  input  1  raw serial line from the pad (asynchronous).
- rxd_o  output  1  synchronised serial line, fed to the UART rxd_i.
- en_i  input  1  level; 1 = arm or continue a measurement, 0 = abort and idle.
- busy_o  output  1  high in any state except IDLE.
- done_o  output  1  one-cycle pulse; divisor_o was updated this cycle.
- err_o  output  1  one-cycle pulse; measurement failed.
- divisor_o  output  DivWidth  last successful divisor; held until the next success.

Behaviour:
- Reset values:
  - Synchroniser flops and rxd_o reset to 1 (line idle).
  - divisor_o = 0; done_o, err_o, busy_o = 0; FSM = IDLE; all counters = 0.
- Synchroniser:
  - rxd_o equals rxd_i delayed by SyncStages cycles.
  - All detection uses the synchronised value s.
  - A falling edge ("fe") is: s = 0 and s on the previous cycle = 1.
- FSM states: IDLE, WAIT_HIGH, ARMED, MEASURE.
  - IDLE: when en_i = 1, go to WAIT_HIGH.
  - WAIT_HIGH: when s = 1, go to ARMED. This ensures a frame already in progress is not measured.
  - ARMED: on fe, go to MEASURE with ivl = 0, total = 0, edges = 0.
  - MEASURE:
    - Each cycle: ivl += 1 and total += 1.
    - On fe: edges += 1 and ivl restarts at 1 in the following cycle.
    - On edge 1, record T1 = ivl (including the fe cycle).
    - On edges 2-4, check that ivl lies in [T1 - (T1>>2), T1 + (T1>>2)]. If ivl < low bound at fe, fail.
    - Fail as soon as ivl > T1 + (T1>>2), without waiting for an edge.
    - On edge 4, total equals the cycles from the first to the fifth falling edge (8 bit periods). Compute div = (total + 64) >> 7.
    - If div = 0 or div > 2^DivWidth - 1: fail.
    - Otherwise: divisor_o <= div, pulse done_o, go to IDLE.
  - Fail: pulse err_o, go to IDLE; divisor_o unchanged.
  - If total or ivl reaches 2^CntWidth - 1 (saturation): fail.
- en_i = 0 in any state: go to IDLE next cycle, with no done_o or err_o pulse.
  - If en_i stays high after done or err, the block re-arms automatically (IDLE -> WAIT_HIGH).
- Priority in the same cycle: en_i = 0 > fail > success.
- done_o and err_o are never high together. Each pulse lasts exactly one cycle, in the cycle FSM returns to IDLE.
- rxd_o is always forwarded, independent of en_i and FSM state; the UART may receive the 'U' frame normally.
- Reset mid-measurement: asynchronous return to reset values; divisor_o is lost (0).

Test Plan:
- Bit period 868 cycles, en_i = 1, send 0x55 8N1 -> done_o pulses once; divisor_o = 54 ((6944+64)>>7); err_o stays 0; rxd_o matches rxd_i delayed by 2 cycles.
- Bit period 27 cycles, send 0x55 -> divisor_o = 2 (216+64=280, >>7 = 2). Then bit period 4 cycles (total 32) -> err_o pulses (div = 0), divisor_o stays 2.
- Bit period 868, send 0x41 -> err_o pulses when ivl reaches 2171 after the second falling edge (T1 = 1736, bound 2170); no done_o.
- Send 0x55 with a 3-cycle low glitch inside bit 1 -> an early fe gives ivl < T1 - (T1>>2) -> err_o; a following clean 0x55 (en_i held) -> done_o with the correct divisor.
- en_i dropped after the third falling edge -> busy_o = 0 next cycle, no done_o or err_o, divisor_o unchanged.
- Assert rst_ni low mid-MEASURE -> all outputs return to reset values immediately.
- Start with the line low at en_i rise -> no measurement until the line goes high, then the 0x55 measures correctly.
